// File: rtl/divider_arbiter_if.sv
// divider_arbiter_if: request/result bundle between requesters and the shared divider
//   req/a_in/b_in : packed per-requester divide requests and operands
//   grant         : one-hot acceptance pulse back to requesters
//   busy          : divider engaged (not idle)
//   res_*         : result channel with valid/ready handshake
interface divider_arbiter_if #(
  parameter int WIDTH_A = 4,
  parameter int WIDTH_B = 4,
  parameter int NUM_REQ = 4
);
  localparam int ID_W = NUM_REQ > 2 ? $clog2(NUM_REQ) : 1;
  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*WIDTH_A-1:0] a_in;
  logic [NUM_REQ*WIDTH_B-1:0] b_in;
  logic [NUM_REQ-1:0]         grant;
  logic                       busy;
  logic                       res_valid;
  logic                       res_ready;
  logic [ID_W-1:0]            res_id;
  logic [WIDTH_A-1:0]         res_q;
  logic [WIDTH_B-1:0]         res_r;
  logic                       res_div0;
  modport master (
    output req, a_in, b_in, res_ready,
    input  grant, busy, res_valid, res_id, res_q, res_r, res_div0
  );
  modport slave (
    input  req, a_in, b_in, res_ready,
    output grant, busy, res_valid, res_id, res_q, res_r, res_div0
  );
endinterface

// File: rtl/divider_arbiter.sv
// divider_arbiter: round-robin arbiter sharing one iterative restoring divider
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : divider_arbiter_if slave (req/a_in/b_in in, grant/busy out, res_* valid/ready result)
module divider_arbiter #(
  parameter int WIDTH_A = 4,
  parameter int WIDTH_B = 4,
  parameter int NUM_REQ = 4
) (
  input logic clk,
  input logic rst,
  divider_arbiter_if.slave bus
);
  localparam int ID_W = NUM_REQ > 2 ? $clog2(NUM_REQ) : 1;
  localparam int CW = WIDTH_A > 1 ? $clog2(WIDTH_A) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [ID_W-1:0] ptr, gid, op_id, res_id;
  logic found, ge, last, res_div0;
  logic [CW-1:0] cnt;
  logic [WIDTH_A-1:0] quot, quot_nxt, a_sel, res_q;
  logic [WIDTH_B-1:0] rem, rem_nxt, div, b_sel, res_r;
  logic [WIDTH_B:0] trial;
  // first requesting index after the last-granted one, wrapping
  always_comb begin
    found = 1'b0;
    gid = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && bus.req[(int'(ptr) + k) % NUM_REQ]) begin
        found = 1'b1;
        gid = ID_W'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end
  assign a_sel = bus.a_in[gid*WIDTH_A +: WIDTH_A];
  assign b_sel = bus.b_in[gid*WIDTH_B +: WIDTH_B];
  // restoring step: shift in the next dividend bit, subtract when it fits
  assign trial = {rem, quot[WIDTH_A-1]};
  assign ge = trial >= {1'b0, div};
  assign rem_nxt = ge ? WIDTH_B'(trial - {1'b0, div}) : trial[WIDTH_B-1:0];
  assign quot_nxt = WIDTH_A'({quot, ge});
  assign last = cnt == CW'(WIDTH_A - 1);
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = found ? (b_sel == '0 ? DONE : RUN) : IDLE;
      RUN:  state_nxt = last ? DONE : RUN;
      DONE: state_nxt = bus.res_ready ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end
  assign bus.grant = (state == IDLE && found && !rst) ? {{(NUM_REQ-1){1'b0}}, 1'b1} << gid : '0;
  assign bus.busy = state != IDLE;
  assign bus.res_valid = state == DONE;
  assign bus.res_id = res_id;
  assign bus.res_q = res_q;
  assign bus.res_r = res_r;
  assign bus.res_div0 = res_div0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      ptr <= ID_W'(NUM_REQ - 1);
      op_id <= '0;
      quot <= '0;
      rem <= '0;
      div <= '0;
      res_id <= '0;
      res_q <= '0;
      res_r <= '0;
      res_div0 <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && found) begin
        ptr <= gid;
        op_id <= gid;
        quot <= a_sel;
        rem <= '0;
        div <= b_sel;
        cnt <= '0;
        // divide-by-zero skips RUN and publishes the saturated result at once
        if (b_sel == '0) begin
          res_id <= gid;
          res_q <= '1;
          res_r <= '0;
          res_div0 <= 1'b1;
        end
      end
      if (state == RUN) begin
        quot <= quot_nxt;
        rem <= rem_nxt;
        cnt <= last ? '0 : cnt + 1'b1;
        if (last) begin
          res_id <= op_id;
          res_q <= quot_nxt;
          res_r <= rem_nxt;
          res_div0 <= 1'b0;
        end
      end
    end
  end
endmodule

// File: doc/divider_arbiter.md
DIVIDER_ARBITER -- requirements
Module: divider_arbiter

Interface
REQ-001 Parameter WIDTH_A, default 4, dividend and quotient width in bits.
REQ-002 Parameter WIDTH_B, default 4, divisor and remainder width in bits; legal range 1..WIDTH_A.
REQ-003 Parameter NUM_REQ, default 4, number of requesters; legal range 2..16; ID_W = max(1, clog2(NUM_REQ)).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req  input  NUM_REQ  per-requester divide request, level, held until granted.
REQ-007 a_in  input  NUM_REQ*WIDTH_A  dividends, requester i at bits [i*WIDTH_A +: WIDTH_A].
REQ-008 b_in  input  NUM_REQ*WIDTH_B  divisors, requester i at bits [i*WIDTH_B +: WIDTH_B].
REQ-009 grant  output  NUM_REQ  one-hot, combinational, one-cycle acceptance pulse.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 res_valid  output  1  result valid.
REQ-012 res_ready  input  1  consumer accepts result.
REQ-013 res_id  output  ID_W  index of requester owning the result.
REQ-014 res_q  output  WIDTH_A  quotient.
REQ-015 res_r  output  WIDTH_B  remainder.
REQ-016 res_div0  output  1  divisor was zero.

Function
REQ-017 The block SHALL contain one shared iterative restoring divider: partial remainder WIDTH_B+1 bits, one quotient bit per cycle, MSB of dividend first; results exact for all A and all B != 0.
REQ-018 FSM states SHALL be IDLE, RUN, DONE.
REQ-019 In IDLE with any req high, grant SHALL assert for exactly one requester that cycle; grant SHALL be all-zero outside IDLE or when req is zero.
REQ-020 Arbitration SHALL be round-robin: search starts at last-granted index + 1, wraps modulo NUM_REQ; pointer updates only on grant.
REQ-021 On the grant edge the block SHALL capture the granted a_in/b_in slice and index; later changes to inputs SHALL NOT affect the operation.
REQ-022 Granted requester SHALL deassert req the cycle after grant or be treated as a new request.
REQ-023 Grant with B != 0: IDLE -> RUN; RUN lasts exactly WIDTH_A cycles (counter 0..WIDTH_A-1), then -> DONE.
REQ-024 Grant with B == 0: IDLE -> DONE directly; res_q = all ones, res_r = 0, res_div0 = 1.
REQ-025 Latency: grant in cycle 0 -> res_valid high in cycle WIDTH_A+1 (B != 0) or cycle 1 (B == 0).
REQ-026 In DONE, res_valid SHALL be high and res_q/res_r/res_id/res_div0 stable until res_valid && res_ready.
REQ-027 res_valid && res_ready SHALL move DONE -> IDLE; no grant in that cycle; next grant earliest the following cycle.
REQ-028 res_valid SHALL be low in IDLE and RUN; res_q/res_r/res_id/res_div0 hold last result outside DONE.
REQ-029 res_ready while res_valid low SHALL be ignored.
REQ-030 Back-to-back throughput SHALL be one operation per WIDTH_A+2 cycles with res_ready held high.

Reset
REQ-031 rst high SHALL immediately force IDLE, counter 0, round-robin pointer NUM_REQ-1 (requester 0 highest first), res_valid 0, busy 0, res_q 0, res_r 0, res_id 0, res_div0 0.
REQ-032 rst mid-RUN or mid-DONE SHALL abandon the operation with no result produced; grant SHALL be all-zero while rst is high.

Verification (WIDTH_A=4, WIDTH_B=4, NUM_REQ=4)
REQ-033 req=0001, A0=13, B0=3, res_ready=1 -> grant=0001 cycle 0, res_valid cycle 5, res_id=0, res_q=4, res_r=1, res_div0=0.
REQ-034 req=1111 held, each cleared after its grant -> grant order 0,1,2,3, grants spaced 6 cycles apart, each result tagged with matching res_id.
REQ-035 Edge operands: A=15,B=1 -> Q=15,R=0; A=7,B=15 -> Q=0,R=7; A=0,B=9 -> Q=0,R=0; A=9,B=0 -> res_valid cycle 1, Q=15, R=0, res_div0=1.
REQ-036 res_ready=0 for 10 cycles in DONE -> res_valid and result fields stable, req=0100 not granted; res_ready=1 -> IDLE next edge, grant=0100 the following cycle.
REQ-037 rst pulse during RUN counter=2 -> outputs at reset values immediately, no res_valid afterwards; post-reset req=1010 -> grant=0010 first.
REQ-038 Random A, B, req and res_ready over 10k operations -> every result matches A/B and A%B, no lost or duplicated grants, no requester starved beyond NUM_REQ-1 intervening grants.
